lenet_image_loader: RTL and testbench

// - Upstream feeder for the LeNet accelerator: accepts a row-major pixel stream over
//   a valid/ready handshake and assembles complete 28x28 frames.
// - Presents each complete frame as a parallel image array that the accelerator

---
 rtl/lenet_pkg.sv | 8 +
 rtl/lenet_frame_bank.sv | 28 ++
 rtl/lenet_image_loader.sv | 101 ++++++++++
 tb/tb_lenet_image_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet accelerator types and dimensions
package lenet_pkg;
  localparam int TOP_BITWIDTH = 9;
  localparam int IMG_DIM      = 28;

  typedef logic signed [TOP_BITWIDTH-1:0] pixel_t;
  typedef pixel_t image_t [IMG_DIM][IMG_DIM];
endpackage

// File: rtl/lenet_frame_bank.sv
// rtl/lenet_frame_bank.sv - one frame of pixel storage with async clear and full-array read
module lenet_frame_bank #(
  parameter int PIX_W   = lenet_pkg::TOP_BITWIDTH,
  parameter int IMG_DIM = lenet_pkg::IMG_DIM,
  localparam int CW     = $clog2(IMG_DIM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [CW-1:0]           wr_row,
  input  logic [CW-1:0]           wr_col,
  input  logic signed [PIX_W-1:0] wr_data,
  output logic signed [PIX_W-1:0] rd_image [IMG_DIM][IMG_DIM]
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < IMG_DIM; r++) begin
        for (int c = 0; c < IMG_DIM; c++) begin
          rd_image[r][c] <= '0;
        end
      end
    end else if (we) begin
      rd_image[wr_row][wr_col] <= wr_data;
    end
  end

endmodule

// File: rtl/lenet_image_loader.sv
// rtl/lenet_image_loader.sv - ping-pong frame assembler feeding the LeNet image buffer
module lenet_image_loader #(
  parameter int PIX_W   = lenet_pkg::TOP_BITWIDTH,
  parameter int IMG_DIM = lenet_pkg::IMG_DIM
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [PIX_W-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [PIX_W-1:0] image [IMG_DIM][IMG_DIM],
  output logic                    frame_valid,
  input  logic                    frame_ack,
  output logic                    err_len
);

  localparam int CW = $clog2(IMG_DIM);
  localparam logic [CW-1:0] LAST = CW'(IMG_DIM - 1);

  logic [CW-1:0] row, col;
  logic [1:0]    full, full_next;
  logic          wr_bank, rd_bank;
  logic          accept, at_end, retire;

  logic signed [PIX_W-1:0] img0 [IMG_DIM][IMG_DIM];
  logic signed [PIX_W-1:0] img1 [IMG_DIM][IMG_DIM];

  // Ready comes from registered flags only, never from in_valid.
  assign in_ready    = !full[wr_bank];
  assign frame_valid = full[rd_bank];
  assign accept      = in_valid && in_ready;
  assign at_end      = (row == LAST) && (col == LAST);
  assign retire      = frame_ack && frame_valid;

  lenet_frame_bank #(.PIX_W(PIX_W), .IMG_DIM(IMG_DIM)) u_bank0 (
    .clk      (clk),
    .reset    (reset),
    .we       (accept && !wr_bank),
    .wr_row   (row),
    .wr_col   (col),
    .wr_data  (in_data),
    .rd_image (img0)
  );

  lenet_frame_bank #(.PIX_W(PIX_W), .IMG_DIM(IMG_DIM)) u_bank1 (
    .clk      (clk),
    .reset    (reset),
    .we       (accept && wr_bank),
    .wr_row   (row),
    .wr_col   (col),
    .wr_data  (in_data),
    .rd_image (img1)
  );

  always_comb begin
    for (int r = 0; r < IMG_DIM; r++) begin
      for (int c = 0; c < IMG_DIM; c++) begin
        image[r][c] = rd_bank ? img1[r][c] : img0[r][c];
      end
    end
  end

  // Completion and retirement always hit different banks, so both may apply.
  always_comb begin
    full_next = full;
    if (accept && at_end) full_next[wr_bank] = 1'b1;
    if (retire)           full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row     <= '0;
      col     <= '0;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      err_len <= 1'b0;
    end else begin
      err_len <= accept && (in_last != at_end);
      full    <= full_next;
      if (retire) rd_bank <= ~rd_bank;
      if (accept) begin
        if (at_end) begin
          row     <= '0;
          col     <= '0;
          wr_bank <= ~wr_bank;
        end else if (in_last) begin
          row <= '0;
          col <= '0;
        end else if (col == LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lenet_image_loader.sv
// tb/tb_lenet_image_loader.sv - directed self-checking bench for lenet_image_loader
module tb_lenet_image_loader;
  localparam int D = 28;
  localparam int N = D * D;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [8:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic signed [8:0] image [D][D];
  logic              frame_valid;
  logic              frame_ack;
  logic              err_len;

  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;
  int gaps_on     = 0;
  int err_base;

  lenet_image_loader #(.PIX_W(9), .IMG_DIM(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .image       (image),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (err_len === 1'b1) err_seen++;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame f pixel (r,c); f=0 is the plain raster ramp (r*28+c)%256-128.
  function automatic int pix(input int f, input int r, input int c);
    return ((r * D + c + f * 37) % 256) - 128;
  endfunction

  function automatic int frame_errs(input int f);
    int n = 0;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        if (int'(image[r][c]) != pix(f, r, c)) n++;
    return n;
  endfunction

  function automatic int nonzero_pixels();
    int n = 0;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        if (image[r][c] !== 9'sd0) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input int v, input logic last, input logic ack);
    int n = 0;
    in_valid = 1'b0;
    if (gaps_on != 0) repeat ($urandom_range(0, 2)) tick();
    in_data  = 9'(v);
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) check("stall_timeout", int'(in_ready), 1);
    frame_ack = ack;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    frame_ack = 1'b0;
  endtask

  // Sends pixels [first, last_idx_excl) of frame f; in_last on pixel last_pos.
  task automatic send_range(input int f, input int first, input int stop, input int last_pos);
    for (int i = first; i < stop; i++)
      send_pixel(pix(f, i / D, i % D), (i == last_pos), 1'b0);
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    frame_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_frame_valid", int'(frame_valid), 0);
    check("rst_err_len", int'(err_len), 0);
    check("rst_image_zero", nonzero_pixels(), 0);
    reset = 1'b0;
    tick();

    // Frame 0: plain ramp, correct in_last
    err_base = err_seen;
    send_range(0, 0, N - 1, N - 1);
    check("f0_not_valid_early", int'(frame_valid), 0);
    send_range(0, N - 1, N, N - 1);
    check("f0_frame_valid", int'(frame_valid), 1);
    check("f0_img00", int'(image[0][0]), -128);
    check("f0_img2727", int'(image[27][27]), pix(0, 27, 27));
    check("f0_img_all", frame_errs(0), 0);
    tick();
    check("f0_no_err", err_seen - err_base, 0);

    // Frame 1 with no ack: both banks full, stream stalls
    send_range(1, 0, N, N - 1);
    check("both_full_in_ready", int'(in_ready), 0);
    check("both_full_shows_f0", frame_errs(0), 0);
    ack_frame();
    check("ack1_shows_f1", frame_errs(1), 0);
    check("ack1_img00", int'(image[0][0]), pix(1, 0, 0));
    check("ack1_in_ready", int'(in_ready), 1);
    check("ack1_frame_valid", int'(frame_valid), 1);
    ack_frame();
    check("ack2_frame_valid", int'(frame_valid), 0);
    tick();
    check("ack_idle_ignored", int'(frame_valid), 0);

    // Early in_last on pixel 100 discards the partial frame
    err_base = err_seen;
    send_range(2, 0, 101, 100);
    check("early_last_err_pulse", int'(err_len), 1);
    check("early_last_no_frame", int'(frame_valid), 0);
    tick();
    check("early_last_err_clear", int'(err_len), 0);
    check("early_last_err_once", err_seen - err_base, 1);
    send_range(3, 0, N, N - 1);
    check("f3_frame_valid", int'(frame_valid), 1);
    check("f3_img00", int'(image[0][0]), pix(3, 0, 0));
    check("f3_img_all", frame_errs(3), 0);
    ack_frame();

    // Missing in_last at final pixel: frame completes, error flagged
    send_range(4, 0, N, -1);
    check("nolast_err_pulse", int'(err_len), 1);
    check("nolast_frame_valid", int'(frame_valid), 1);
    check("nolast_img_all", frame_errs(4), 0);

    // Frame 5 completes on the same edge that frame 4 is acked
    send_range(5, 0, N - 1, N - 1);
    send_pixel(pix(5, D - 1, D - 1), 1'b1, 1'b1);
    check("simul_frame_valid", int'(frame_valid), 1);
    check("simul_img_all", frame_errs(5), 0);
    check("simul_in_ready", int'(in_ready), 1);

    // Reset at pixel 400 with gapped input, then a clean gapped frame
    gaps_on = 1;
    send_range(6, 0, 400, N - 1);
    check("pre_rst_frame_valid", int'(frame_valid), 1);
    reset = 1'b1;
    #1;
    check("midrst_frame_valid", int'(frame_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_err_len", int'(err_len), 0);
    check("midrst_image_zero", nonzero_pixels(), 0);
    #2;
    reset = 1'b0;
    tick();
    err_base = err_seen;
    send_range(7, 0, N, N - 1);
    check("f7_frame_valid", int'(frame_valid), 1);
    check("f7_img00", int'(image[0][0]), pix(7, 0, 0));
    check("f7_img_all", frame_errs(7), 0);
    tick();
    check("f7_no_err", err_seen - err_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
